// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the two async FIFOs, the UART transmitter and the arbiter.
// master = arbiter side, slave = FIFO/transmitter side.
interface fifo_rd_arbiter_if #(
    parameter int bus_width = 8
);
    logic                 empty0;
    logic [bus_width-1:0] rdata0;
    logic                 r_en0;
    logic                 empty1;
    logic [bus_width-1:0] rdata1;
    logic                 r_en1;
    logic                 tx_busy;
    logic [bus_width-1:0] tx_data;
    logic                 tx_valid;
    logic                 grant;
    logic                 active;

    modport master (
        input  empty0, rdata0, empty1, rdata1, tx_busy,
        output r_en0, r_en1, tx_data, tx_valid, grant, active
    );

    modport slave (
        output empty0, rdata0, empty1, rdata1, tx_busy,
        input  r_en0, r_en1, tx_data, tx_valid, grant, active
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin drain of two FIFOs into one UART transmitter, with a burst limit
// per source and a valid/busy handshake per word.
//
// state     | meaning
// IDLE      | waiting for a non-empty FIFO; grant, latch word and pop on exit
// ISSUE     | tx_valid high, waiting for tx_busy to rise
// WAIT_DONE | transmitter serialising, waiting for tx_busy to fall
module fifo_rd_arbiter #(
    parameter int bus_width = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               r_clk,
    input  logic               r_rst,
    fifo_rd_arbiter_if.master  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_fire;
    logic                 w_tx_valid;
    logic                 w_active;
    logic                 w_ne0;
    logic                 w_ne1;
    logic                 w_sel;
    logic [CW-1:0]        w_burst_nxt;
    logic [bus_width-1:0] r_tx_data;
    logic                 r_grant;
    logic                 r_last_grant;
    logic                 r_pop0;
    logic                 r_pop1;
    logic [CW-1:0]        r_burst_cnt;

    assign w_ne0 = ~bus.empty0;
    assign w_ne1 = ~bus.empty1;

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Empty flags are only looked at in IDLE, so a flag still stale from the
    // previous pop can never trigger a second pop.
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_tx_valid  = 1'b0;
        w_active    = 1'b1;
        case (r_state)
            IDLE: begin
                w_active = 1'b0;
                if (w_ne0 || w_ne1) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_tx_valid = 1'b1;
                if (bus.tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_sel       = w_ne1;
        w_burst_nxt = CW'(1);
        if (w_ne0 && w_ne1) begin
            w_sel = (r_burst_cnt >= BURST_MAX) ? ~r_last_grant : r_last_grant;
        end
        if (w_sel == r_last_grant) begin
            w_burst_nxt = (r_burst_cnt >= BURST_MAX) ? BURST_MAX : r_burst_cnt + CW'(1);
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_tx_data    <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b0;
            r_pop0       <= 1'b0;
            r_pop1       <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            r_pop0 <= 1'b0;
            r_pop1 <= 1'b0;
            if (w_fire) begin
                r_tx_data    <= w_sel ? bus.rdata1 : bus.rdata0;
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
                r_pop0       <= ~w_sel;
                r_pop1       <= w_sel;
                r_burst_cnt  <= w_burst_nxt;
            end
        end
    end

    assign bus.r_en0    = r_pop0;
    assign bus.r_en1    = r_pop1;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = w_tx_valid;
    assign bus.grant    = r_grant;
    assign bus.active   = w_active;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: queue-based FIFO and transmitter models, a grant-history
// reference model, directed scenarios and a randomized traffic phase.
module tb_fifo_rd_arbiter;
    localparam int BW   = 8;
    localparam int MAXB = 4;

    logic r_clk = 1'b0;
    logic r_rst = 1'b0;

    fifo_rd_arbiter_if #(.bus_width(BW)) bus ();

    fifo_rd_arbiter #(.bus_width(BW), .MAX_BURST(MAXB)) dut (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .bus   (bus)
    );

    always #5 r_clk = ~r_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         hist[$];
    bit         glog[$];
    logic [7:0] d0log[$];
    logic [7:0] d1log[$];
    int  pops, ren0_cycles, vcnt, last_vcnt, cyc, busy_fall_cyc, idle_cyc;
    int  lat_cnt, tx_cnt, cfg_lat, cfg_dur;
    bit  busy_phase, stuck, rnd_mode, prev_valid, prev_active, snap_ne0, snap_ne1;
    logic [7:0] hold_d;
    bit  hold_g;

    // Expected source from the grant history: length of the trailing run of
    // identical grants decides whether the current holder must yield.
    function automatic bit model_pick(bit ne0, bit ne1);
        bit last;
        int run;
        last = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
        run  = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) run++;
        if (ne0 && !ne1) return 1'b0;
        if (ne1 && !ne0) return 1'b1;
        return (run >= MAXB) ? ~last : last;
    endfunction

    always @(negedge r_clk) begin
        bit         es;
        logic [7:0] ed;
        cyc++;
        if (!r_rst) begin
            bus.tx_busy = 1'b0;
            busy_phase  = 1'b0;
            lat_cnt     = cfg_lat;
            prev_valid  = 1'b0;
            prev_active = 1'b0;
            vcnt        = 0;
        end else begin
            if (bus.r_en0 || bus.r_en1) begin
                es = model_pick(snap_ne0, snap_ne1);
                chk("ren_excl", {31'b0, bus.r_en0 & bus.r_en1}, 0);
                chk("ren_first", {31'b0, prev_valid}, 0);
                chk("valid_w_ren", {31'b0, bus.tx_valid}, 1);
                chk("pop_had_data", {31'b0, snap_ne0 | snap_ne1}, 1);
                chk("grant", {31'b0, bus.grant}, {31'b0, es});
                chk("ren_src", {31'b0, bus.r_en1}, {31'b0, es});
                ed = 8'h00;
                if (!es && q0.size() > 0) begin
                    ed = q0.pop_front();
                    d0log.push_back(ed);
                end else if (es && q1.size() > 0) begin
                    ed = q1.pop_front();
                    d1log.push_back(ed);
                end
                chk("tx_data", {24'b0, bus.tx_data}, {24'b0, ed});
                hold_d = ed;
                hold_g = es;
                hist.push_back(es);
                glog.push_back(bus.grant);
                pops++;
            end else begin
                chk("hold_data", {24'b0, bus.tx_data}, {24'b0, hold_d});
                chk("hold_grant", {31'b0, bus.grant}, {31'b0, hold_g});
            end
            if (bus.r_en0) ren0_cycles++;
            if (bus.tx_valid) vcnt++;
            else if (prev_valid) begin
                last_vcnt = vcnt;
                vcnt = 0;
            end
            if (prev_active && !bus.active) idle_cyc = cyc;
            prev_valid  = bus.tx_valid;
            prev_active = bus.active;

            if (busy_phase) begin
                if (!stuck) begin
                    if (tx_cnt == 0) begin
                        bus.tx_busy   = 1'b0;
                        busy_phase    = 1'b0;
                        busy_fall_cyc = cyc;
                        if (rnd_mode) begin
                            cfg_lat = $urandom_range(0, 3);
                            cfg_dur = $urandom_range(1, 4);
                        end
                        lat_cnt = cfg_lat;
                    end else tx_cnt--;
                end
            end else if (bus.tx_valid) begin
                if (lat_cnt == 0) begin
                    bus.tx_busy = 1'b1;
                    busy_phase  = 1'b1;
                    tx_cnt      = cfg_dur - 1;
                end else lat_cnt--;
            end else lat_cnt = cfg_lat;
        end
        bus.empty0 = (q0.size() == 0);
        bus.empty1 = (q1.size() == 0);
        bus.rdata0 = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.rdata1 = (q1.size() > 0) ? q1[0] : 8'h00;
        snap_ne0   = !bus.empty0;
        snap_ne1   = !bus.empty1;
    end

    task automatic do_reset();
        r_rst = 1'b0;
        q0.delete(); q1.delete(); hist.delete(); glog.delete();
        d0log.delete(); d1log.delete();
        pops = 0; ren0_cycles = 0; last_vcnt = 0;
        stuck = 1'b0; rnd_mode = 1'b0; cfg_lat = 0; cfg_dur = 1;
        hold_d = 8'h00; hold_g = 1'b0;
        repeat (3) @(posedge r_clk);
        #1 r_rst = 1'b1;
    endtask

    task automatic wait_pops(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && pops < target; i++) @(posedge r_clk);
        #1;
        if (pops < target) chk({tag, "_timeout"}, pops, target);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge r_clk);
            #1;
            done = !bus.active && !busy_phase && q0.size() == 0 && q1.size() == 0;
        end
        if (!done) chk({tag, "_timeout"}, {31'b0, bus.active}, 0);
        repeat (2) @(posedge r_clk);
        #1;
    endtask

    bit exp3 [20] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};
    bit exp4 [7]  = '{1,1,1,1,0,1,1};

    initial begin
        int pushed;
        bus.empty0 = 1'b1; bus.empty1 = 1'b1;
        bus.rdata0 = '0;   bus.rdata1 = '0;
        bus.tx_busy = 1'b0;
        cfg_lat = 0; cfg_dur = 1;

        // idle after reset
        do_reset();
        repeat (20) @(posedge r_clk);
        #1;
        chk("t1_active", {31'b0, bus.active}, 0);
        chk("t1_valid", {31'b0, bus.tx_valid}, 0);
        chk("t1_ren", {30'b0, bus.r_en1, bus.r_en0}, 0);
        chk("t1_data", {24'b0, bus.tx_data}, 0);
        chk("t1_pops", pops, 0);

        // single word, slow transmitter
        do_reset();
        cfg_lat = 2; cfg_dur = 10;
        q0.push_back(8'hA5);
        wait_pops(1, 20, "t2_pop");
        wait_idle(80, "t2_idle");
        chk("t2_grant", {31'b0, glog.size() > 0 ? glog[0] : 1'b1}, 0);
        chk("t2_data", {24'b0, d0log.size() > 0 ? d0log[0] : 8'h00}, 32'hA5);
        chk("t2_ren0_cycles", ren0_cycles, 1);
        chk("t2_valid_cycles", last_vcnt, 3);
        chk("t2_idle_lat", idle_cyc - busy_fall_cyc, 1);

        // both full, burst limit alternation
        do_reset();
        for (int i = 0; i < 10; i++) begin
            q0.push_back(8'(i));
            q1.push_back(8'(8'h10 + i));
        end
        wait_idle(400, "t3_idle");
        chk("t3_count", glog.size(), 20);
        for (int i = 0; i < 20 && i < glog.size(); i++) chk("t3_seq", {31'b0, glog[i]}, {31'b0, exp3[i]});
        for (int i = 0; i < 10 && i < d0log.size() && i < d1log.size(); i++) begin
            chk("t3_d0", {24'b0, d0log[i]}, i);
            chk("t3_d1", {24'b0, d1log[i]}, 32'h10 + i);
        end

        // FIFO0 arrives mid-burst of FIFO1
        do_reset();
        for (int i = 0; i < 6; i++) q1.push_back(8'(8'h20 + i));
        wait_pops(2, 40, "t4_pop2");
        q0.push_back(8'h77);
        wait_idle(200, "t4_idle");
        chk("t4_count", glog.size(), 7);
        for (int i = 0; i < 7 && i < glog.size(); i++) chk("t4_seq", {31'b0, glog[i]}, {31'b0, exp4[i]});

        // reset while in WAIT_DONE with busy high
        do_reset();
        cfg_dur = 30;
        q0.push_back(8'h5A);
        wait_pops(1, 20, "t5_pop");
        repeat (3) @(posedge r_clk);
        #3;
        chk("t5_pre_busy", {31'b0, bus.tx_busy}, 1);
        r_rst = 1'b0;
        #1;
        chk("t5_rst_valid", {31'b0, bus.tx_valid}, 0);
        chk("t5_rst_active", {31'b0, bus.active}, 0);
        chk("t5_rst_data", {24'b0, bus.tx_data}, 0);
        chk("t5_rst_grant", {31'b0, bus.grant}, 0);
        do_reset();
        cfg_dur = 2;
        q0.push_back(8'h3C);
        wait_pops(1, 20, "t5_regrant");
        wait_idle(60, "t5_idle");
        chk("t5_data", {24'b0, d0log.size() > 0 ? d0log[0] : 8'h00}, 32'h3C);
        chk("t5_valid_end", {31'b0, bus.tx_valid}, 0);

        // transmitter stuck busy
        do_reset();
        stuck = 1'b1;
        for (int i = 0; i < 3; i++) q0.push_back(8'(8'h40 + i));
        repeat (60) @(posedge r_clk);
        #1;
        chk("t6_pops", pops, 1);
        chk("t6_active", {31'b0, bus.active}, 1);
        chk("t6_valid", {31'b0, bus.tx_valid}, 0);
        chk("t6_left", q0.size(), 2);

        // randomized traffic against the reference model
        do_reset();
        rnd_mode = 1'b1;
        cfg_lat = $urandom_range(0, 3);
        cfg_dur = $urandom_range(1, 4);
        pushed = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge r_clk);
            #1;
            if ($urandom_range(0, 11) == 0) begin q0.push_back(8'($urandom)); pushed++; end
            if ($urandom_range(0, 11) == 0) begin q1.push_back(8'($urandom)); pushed++; end
        end
        wait_idle(3000, "t7_drain");
        chk("t7_total", pops, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
